sar_nbit_ctrl: RTL and testbench

//  Parametrised successive-approximation ADC controller: the N-bit, multi-channel successor of the 5-bit SAR FSM.

---
 rtl/sar_pkg.sv | 38 +++
 rtl/sar_cycle_timer.sv | 50 +++++
 rtl/sar_nbit_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sar_nbit_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// ============================================================================
// sar_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the N-bit successive-approximation ADC controller:
//   - state encoding (plain localparams so the encoding stays stable for
//     legacy tooling and waveform scripts)
//   - width of the shared cycle timer
//   - cw_of(): width helper used for the channel and bit-index buses
// ============================================================================
package sar_pkg;

    localparam int ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_RESET     = 4'd0;
    localparam state_t ST_WAIT      = 4'd1;
    localparam state_t ST_SAMPLE    = 4'd2;
    localparam state_t ST_HOLD      = 4'd3;
    localparam state_t ST_HIGH      = 4'd4;
    localparam state_t ST_SETTLE    = 4'd5;
    localparam state_t ST_CHECK     = 4'd6;
    localparam state_t ST_STOREWAIT = 4'd7;
    localparam state_t ST_STORE     = 4'd8;
    localparam state_t ST_DONE      = 4'd9;

    // Sample and settle counts both fit in 0..15.
    localparam int TMR_W = 4;

    // Bits needed to address n items, never less than one bit so that a
    // single-channel build still has a legal 1-bit select bus.
    function automatic int cw_of(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sar_cycle_timer.sv
// ============================================================================
// sar_cycle_timer
// ----------------------------------------------------------------------------
// Loadable 4-bit down-counter with a zero flag. The controller loads it with
// (cycles - 1) on entry to a timed state and leaves that state on the cycle
// where zero is seen, so a load of 0 gives a one-cycle stay.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-low reset (count cleared)
//   load      in   load load_val this cycle (has priority over dec)
//   load_val  in   value to load
//   dec       in   decrement this cycle; saturates at zero
//   zero      out  count is zero
// ============================================================================
module sar_cycle_timer
    import sar_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Saturating at zero keeps a stray decrement from wrapping to 15.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_nbit_ctrl.sv
// ============================================================================
// sar_nbit_ctrl
// ----------------------------------------------------------------------------
// N-bit, multi-channel successive-approximation ADC controller. Drives the
// sample/hold switch, the DAC trial word and the analog mux, resolves one bit
// per trial from the comparator, and latches the result with its channel tag.
// Every output is a register; each state performs its action on the clock
// edge that leaves it.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   nStartCnv  in   active-low start request, only looked at in WAIT
//   chSel      in   channel to convert, captured when a start is accepted
//   CompOut    in   comparator, 1 = DAC above input -> drop the trial bit
//   SH         out  sample/hold control, 1 = sample
//   MuxSel     out  analog mux select
//   B          out  DAC trial word
//   dataOut    out  last completed conversion result
//   chanOut    out  channel tag belonging to dataOut
//   nEndCnv    out  0 = idle / result valid, 1 = conversion running
// ============================================================================
module sar_nbit_ctrl
    import sar_pkg::*;
#(
    parameter  int NBITS      = 8,
    parameter  int NCHAN      = 4,
    parameter  int SAMPLE_CYC = 1,
    parameter  int SETTLE_CYC = 1,
    localparam int CW         = cw_of(NCHAN)
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             nStartCnv,
    input  logic [CW-1:0]    chSel,
    input  logic             CompOut,
    output logic             SH,
    output logic [CW-1:0]    MuxSel,
    output logic [NBITS-1:0] B,
    output logic [NBITS-1:0] dataOut,
    output logic [CW-1:0]    chanOut,
    output logic             nEndCnv
);

    localparam int               KW          = cw_of(NBITS);
    localparam logic [KW-1:0]    K_TOP       = KW'(NBITS - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LOAD = TMR_W'(SAMPLE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    state_t           state_q, state_d;
    logic             sh_q, sh_d;
    logic [CW-1:0]    mux_q, mux_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic             nend_q, nend_d;
    logic [KW-1:0]    k_q, k_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // One timer serves both SAMPLE and SETTLE; the two never overlap.
    sar_cycle_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state and next-output logic. Trial bit k is set in HIGH and,
    // after the optional settle wait, kept or dropped in CHECK using the
    // comparator that has been looking at the trial word.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        mux_d        = mux_q;
        b_d          = b_q;
        data_d       = data_q;
        chan_d       = chan_q;
        nend_d       = nend_q;
        k_d          = k_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!nStartCnv) begin
                    mux_d        = chSel;
                    tmr_load     = 1'b1;
                    tmr_load_val = SAMPLE_LOAD;
                    state_d      = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sh_d   = 1'b1;
                b_d    = '1;
                nend_d = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                sh_d    = 1'b0;
                b_d     = '0;
                k_d     = K_TOP;
                state_d = ST_HIGH;
            end
            ST_HIGH: begin
                b_d[k_q] = 1'b1;
                if (SETTLE_CYC > 0) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                if (CompOut) begin
                    b_d[k_q] = 1'b0;
                end
                if (k_q == '0) begin
                    state_d = ST_STOREWAIT;
                end else begin
                    k_d     = k_q - 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_STOREWAIT: begin
                state_d = ST_STORE;
            end
            ST_STORE: begin
                data_d  = b_q;
                chan_d  = mux_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                nend_d  = 1'b0;
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // A reset mid-conversion throws away the partial result along with
    // everything else.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            sh_q    <= 1'b0;
            mux_q   <= '0;
            b_q     <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            nend_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mux_q   <= mux_d;
            b_q     <= b_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            nend_q  <= nend_d;
            k_q     <= k_d;
        end
    end

    assign SH      = sh_q;
    assign MuxSel  = mux_q;
    assign B       = b_q;
    assign dataOut = data_q;
    assign chanOut = chan_q;
    assign nEndCnv = nend_q;

endmodule

// File: tb/tb_sar_nbit_ctrl.sv
// ============================================================================
// tb_sar_nbit_ctrl
// ----------------------------------------------------------------------------
// Directed bench for sar_nbit_ctrl. A default 8-bit/4-channel instance and a
// 5-bit/1-channel/no-settle instance share clock and reset. Each comparator
// is modelled as CompOut = (B > vin[MuxSel]).
// Time t is the number of rising edges since the edge that accepted the
// start request; outputs are sampled on falling edges.
// ============================================================================
module tb_sar_nbit_ctrl;

    // Conversion latency: sample + hold + per-bit trials + storewait/store/done.
    localparam int LAT   = 4 + 1 + 8 * (2 + 1);
    localparam int S_LAT = 4 + 1 + 5 * (2 + 0);

    logic       clock;
    logic       reset;
    logic       nStartCnv;
    logic [1:0] chSel;
    logic       CompOut;
    logic       SH;
    logic [1:0] MuxSel;
    logic [7:0] B;
    logic [7:0] dataOut;
    logic [1:0] chanOut;
    logic       nEndCnv;
    logic [7:0] vin [4];

    logic       s_nStartCnv;
    logic [0:0] s_chSel;
    logic       s_CompOut;
    logic       s_SH;
    logic [0:0] s_MuxSel;
    logic [4:0] s_B;
    logic [4:0] s_dataOut;
    logic [0:0] s_chanOut;
    logic       s_nEndCnv;
    logic [4:0] s_vin;

    int edge_cnt = 0;
    int n_cmp    = 0;
    int n_bad    = 0;

    sar_nbit_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .nStartCnv (nStartCnv),
        .chSel     (chSel),
        .CompOut   (CompOut),
        .SH        (SH),
        .MuxSel    (MuxSel),
        .B         (B),
        .dataOut   (dataOut),
        .chanOut   (chanOut),
        .nEndCnv   (nEndCnv)
    );

    sar_nbit_ctrl #(
        .NBITS      (5),
        .NCHAN      (1),
        .SAMPLE_CYC (1),
        .SETTLE_CYC (0)
    ) dut_small (
        .clock     (clock),
        .reset     (reset),
        .nStartCnv (s_nStartCnv),
        .chSel     (s_chSel),
        .CompOut   (s_CompOut),
        .SH        (s_SH),
        .MuxSel    (s_MuxSel),
        .B         (s_B),
        .dataOut   (s_dataOut),
        .chanOut   (s_chanOut),
        .nEndCnv   (s_nEndCnv)
    );

    assign CompOut   = (B > vin[MuxSel]);
    assign s_CompOut = (s_B > s_vin);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Request one conversion on the default instance; e0 is the edge count
    // of the accepting edge.
    task automatic start_conv(input logic [1:0] ch, output int e0);
        @(negedge clock);
        nStartCnv = 1'b0;
        chSel     = ch;
        @(negedge clock);
        nStartCnv = 1'b1;
        e0        = edge_cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({SH, B, dataOut, chanOut, MuxSel, nEndCnv} !== 22'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {SH, B, dataOut, chanOut, MuxSel, nEndCnv});
        end
        n_cmp++;
        if ({s_SH, s_B, s_dataOut, s_chanOut, s_MuxSel, s_nEndCnv} !== 14'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs_small: got %h expected 0",
                     {s_SH, s_B, s_dataOut, s_chanOut, s_MuxSel, s_nEndCnv});
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({nEndCnv, SH, dataOut} !== 10'h0) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset: got %h expected 0", {nEndCnv, SH, dataOut});
        end
    endtask

    task automatic test_basic();
        int  e0, t;
        bit  done;
        vin[2] = 8'hA5;
        start_conv(2'd2, e0);
        n_cmp++;
        if (MuxSel !== 2'd2) begin
            n_bad++;
            $display("[TB] FAIL basic_muxsel: got %0d expected 2", MuxSel);
        end
        done = 1'b0;
        t    = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            t = edge_cnt - e0;
            if (t == 1) begin
                n_cmp++;
                if ({SH, B, nEndCnv} !== {1'b1, 8'hFF, 1'b1}) begin
                    n_bad++;
                    $display("[TB] FAIL basic_sample: got %h expected %h", {SH, B, nEndCnv}, {1'b1, 8'hFF, 1'b1});
                end
            end
            if (t == 2) begin
                n_cmp++;
                if ({SH, B} !== 9'h000) begin
                    n_bad++;
                    $display("[TB] FAIL basic_hold: got %h expected 000", {SH, B});
                end
            end
            if (!nEndCnv) done = 1'b1;
        end
        n_cmp++;
        if (!done || t != LAT) begin
            n_bad++;
            $display("[TB] FAIL basic_latency: got %0d (done=%0d) expected %0d", t, done, LAT);
        end
        n_cmp++;
        if ({dataOut, chanOut} !== {8'hA5, 2'd2}) begin
            n_bad++;
            $display("[TB] FAIL basic_result: got %h/%0d expected a5/2", dataOut, chanOut);
        end
    endtask

    task automatic test_extremes();
        int         e0, t;
        bit         done;
        logic [7:0] exp_b;
        vin[0] = 8'h00;
        vin[3] = 8'hFF;
        start_conv(2'd0, e0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            t = edge_cnt - e0;
            // The trial bit appears in B on the HIGH edge, every third edge.
            if (t >= 3 && t <= 24 && ((t - 3) % 3) == 0) begin
                exp_b = 8'h80 >> ((t - 3) / 3);
                n_cmp++;
                if (B !== exp_b) begin
                    n_bad++;
                    $display("[TB] FAIL zero_trace_t%0d: got %h expected %h", t, B, exp_b);
                end
            end
            if (t == 26) begin
                n_cmp++;
                if (B !== 8'h00) begin
                    n_bad++;
                    $display("[TB] FAIL zero_trace_end: got %h expected 00", B);
                end
            end
            if (!nEndCnv) done = 1'b1;
        end
        n_cmp++;
        if (!done || {dataOut, chanOut} !== {8'h00, 2'd0}) begin
            n_bad++;
            $display("[TB] FAIL zero_result: got %h/%0d (done=%0d) expected 00/0", dataOut, chanOut, done);
        end

        start_conv(2'd3, e0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (!nEndCnv && (edge_cnt - e0) > 1) done = 1'b1;
        end
        n_cmp++;
        if (!done || {dataOut, chanOut} !== {8'hFF, 2'd3}) begin
            n_bad++;
            $display("[TB] FAIL full_result: got %h/%0d (done=%0d) expected ff/3", dataOut, chanOut, done);
        end
    endtask

    task automatic test_back_to_back();
        int         fall_t [3];
        int         nf, changes;
        logic [7:0] prev_data;
        logic       prev_nend;
        vin[1] = 8'h3C;
        @(negedge clock);
        nStartCnv = 1'b0;
        chSel     = 2'd1;
        prev_data = dataOut;
        prev_nend = nEndCnv;
        nf        = 0;
        changes   = 0;
        for (int i = 0; i < 200 && nf < 3; i++) begin
            @(negedge clock);
            if (dataOut !== prev_data) changes++;
            prev_data = dataOut;
            if (prev_nend && !nEndCnv) begin
                fall_t[nf] = edge_cnt;
                n_cmp++;
                if ({dataOut, chanOut} !== {8'h3C, 2'd1}) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_result%0d: got %h/%0d expected 3c/1", nf, dataOut, chanOut);
                end
                nf++;
                if (nf == 3) nStartCnv = 1'b1;
            end
            prev_nend = nEndCnv;
        end
        nStartCnv = 1'b1;
        n_cmp++;
        if (nf != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", nf);
        end else begin
            // Each period is the latency plus the single WAIT cycle.
            n_cmp++;
            if ((fall_t[1] - fall_t[0]) != LAT + 1 || (fall_t[2] - fall_t[1]) != LAT + 1) begin
                n_bad++;
                $display("[TB] FAIL b2b_spacing: got %0d,%0d expected %0d",
                         fall_t[1] - fall_t[0], fall_t[2] - fall_t[1], LAT + 1);
            end
        end
        n_cmp++;
        if (changes != 1) begin
            n_bad++;
            $display("[TB] FAIL b2b_data_stable: got %0d changes expected 1", changes);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (nEndCnv !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL b2b_stop: got %b expected 0", nEndCnv);
        end
    endtask

    task automatic test_ignore_inputs();
        int  e0, t;
        bit  done;
        vin[0] = 8'h5A;
        start_conv(2'd0, e0);
        done = 1'b0;
        t    = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            t = edge_cnt - e0;
            if (t >= 3 && t <= 15) begin
                nStartCnv = t[0];
                chSel     = 2'(t);
            end else begin
                nStartCnv = 1'b1;
            end
            if (t == 8 || t == 14) begin
                n_cmp++;
                if ({MuxSel, chanOut} !== {2'd0, 2'd1}) begin
                    n_bad++;
                    $display("[TB] FAIL ignore_mux_t%0d: got %0d/%0d expected 0/1", t, MuxSel, chanOut);
                end
            end
            if (!nEndCnv && t > 1) done = 1'b1;
        end
        n_cmp++;
        if (!done || t != LAT || {dataOut, chanOut} !== {8'h5A, 2'd0}) begin
            n_bad++;
            $display("[TB] FAIL ignore_result: got %h/%0d lat %0d expected 5a/0 lat %0d",
                     dataOut, chanOut, t, LAT);
        end
    endtask

    task automatic test_mid_reset();
        int  e0, t;
        bit  done;
        vin[2] = 8'hA5;
        start_conv(2'd2, e0);
        t = 0;
        for (int i = 0; i < 40 && t < 13; i++) begin
            @(negedge clock);
            t = edge_cnt - e0;
        end
        // CHECK of bit 4: bits 7..5 resolved to 101, bit 4 on trial.
        n_cmp++;
        if (t != 13 || B !== 8'hB0) begin
            n_bad++;
            $display("[TB] FAIL midrst_trial: got %h at t=%0d expected b0 at t=13", B, t);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({SH, B, dataOut, chanOut, MuxSel, nEndCnv} !== 22'h0) begin
            n_bad++;
            $display("[TB] FAIL midrst_outputs: got %h expected 0",
                     {SH, B, dataOut, chanOut, MuxSel, nEndCnv});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({nEndCnv, SH, B} !== 10'h0) begin
            n_bad++;
            $display("[TB] FAIL midrst_idle: got %h expected 0", {nEndCnv, SH, B});
        end
        start_conv(2'd2, e0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            t = edge_cnt - e0;
            if (!nEndCnv && t > 1) done = 1'b1;
        end
        n_cmp++;
        if (!done || t != LAT || {dataOut, chanOut} !== {8'hA5, 2'd2}) begin
            n_bad++;
            $display("[TB] FAIL midrst_recover: got %h/%0d lat %0d expected a5/2 lat %0d",
                     dataOut, chanOut, t, LAT);
        end
    endtask

    task automatic test_small();
        logic [4:0] vecs [2];
        int         e0, t;
        bit         done;
        vecs[0] = 5'h13;
        vecs[1] = 5'h0A;
        for (int v = 0; v < 2; v++) begin
            s_vin = vecs[v];
            @(negedge clock);
            s_nStartCnv = 1'b0;
            s_chSel     = 1'b0;
            @(negedge clock);
            s_nStartCnv = 1'b1;
            e0   = edge_cnt;
            done = 1'b0;
            t    = 0;
            for (int i = 0; i < 60 && !done; i++) begin
                @(negedge clock);
                t = edge_cnt - e0;
                if (!s_nEndCnv && t > 1) done = 1'b1;
            end
            n_cmp++;
            if (!done || t != S_LAT) begin
                n_bad++;
                $display("[TB] FAIL small_latency%0d: got %0d (done=%0d) expected %0d", v, t, done, S_LAT);
            end
            n_cmp++;
            if ({s_dataOut, s_chanOut} !== {vecs[v], 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL small_result%0d: got %h/%0d expected %h/0", v, s_dataOut, s_chanOut, vecs[v]);
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        nStartCnv   = 1'b1;
        chSel       = 2'd0;
        s_nStartCnv = 1'b1;
        s_chSel     = 1'b0;
        s_vin       = 5'h00;
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;

        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_ignore_inputs();
        test_mid_reset();
        test_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
